// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - register field layout, scan states and list entry for the sprite line scheduler
package sprite_pkg;

  localparam int STATUS_HI = 31;
  localparam int STATUS_LO = 29;
  localparam int X_HI      = 28;
  localparam int X_LO      = 19;
  localparam int Y_HI      = 18;
  localparam int Y_LO      = 9;
  localparam int OFFSET_HI = 8;
  localparam int OFFSET_LO = 0;

  localparam logic [2:0] STATUS_ACTIVE = 3'b001;
  localparam int SPRITE_LINE = 20;

  localparam int IDX_W    = 5;
  localparam int COORD_W  = 10;
  localparam int ROW_W    = 5;
  localparam int OFFSET_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]    index;
    logic [COORD_W-1:0]  x;
    logic [ROW_W-1:0]    row;
    logic [OFFSET_W-1:0] offset;
  } sprite_entry_t;

endpackage

// File: rtl/sprite_slot_match.sv
// rtl/sprite_slot_match.sv - one front-list slot: horizontal range compare and in-sprite column
module sprite_slot_match
  import sprite_pkg::*;
#(
  parameter int LINE_LEN = SPRITE_LINE
) (
  input  logic [COORD_W-1:0] slot_x,
  input  logic               en,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] pixel_x,
  output logic               match,
  output logic [4:0]         col
);

  logic [COORD_W:0] lo, hi, px;

  // One extra bit so a sprite near the right edge never wraps onto column 0
  assign lo    = {1'b0, slot_x};
  assign hi    = lo + (COORD_W+1)'(LINE_LEN);
  assign px    = {1'b0, pixel_x};
  assign match = en && pixel_valid && (px >= lo) && (px < hi);
  assign col   = 5'(pixel_x - slot_x);

endmodule

// File: rtl/sprite_line_scheduler.sv
// rtl/sprite_line_scheduler.sv - scans the sprite bank for the next line and resolves pixels against the current line's list
module sprite_line_scheduler #(
  parameter int NUM_REGS     = 32,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_LINE  = 20,
  parameter int COORD_W      = 10,
  parameter int REG_W        = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        line_start,
  input  logic [COORD_W-1:0]          next_y,
  output logic                        rd_en,
  output logic [$clog2(NUM_REGS)-1:0] rd_addr,
  input  logic [REG_W-1:0]            rd_data,
  input  logic                        pixel_valid,
  input  logic [COORD_W-1:0]          pixel_x,
  output logic                        hit,
  output logic [$clog2(NUM_REGS)-1:0] hit_index,
  output logic [4:0]                  hit_col,
  output logic [4:0]                  hit_row,
  output logic [8:0]                  hit_offset,
  output logic                        scan_busy,
  output logic                        scan_done,
  output logic                        overflow,
  output logic                        late
);
  import sprite_pkg::*;

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int SW = $clog2(MAX_PER_LINE);

  scan_state_t   state, state_nx;
  logic          rd_vld_q;
  logic [AW-1:0] rd_idx_q;
  logic [COORD_W-1:0] ny_q;
  sprite_entry_t back_q  [MAX_PER_LINE];
  sprite_entry_t front_q [MAX_PER_LINE];
  logic [CW-1:0] back_cnt, front_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    scan_busy = 1'b0;
    scan_done = 1'b0;
    case (state)
      SCAN: begin
        rd_en     = 1'b1;
        scan_busy = 1'b1;
        if (rd_addr == AW'(NUM_REGS - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        scan_busy = 1'b1;
        scan_done = !line_start;
        state_nx  = IDLE;
      end
      default: ;
    endcase
    if (line_start) state_nx = SCAN;
  end

  logic [2:0]          w_status;
  logic [COORD_W-1:0]  w_x, w_y;
  logic [OFFSET_W-1:0] w_off;
  logic [COORD_W:0]    ny_ext, y_lo, y_hi;
  logic                qualify;
  sprite_entry_t       new_entry;

  assign w_status  = rd_data[STATUS_HI:STATUS_LO];
  assign w_x       = rd_data[X_HI:X_LO];
  assign w_y       = rd_data[Y_HI:Y_LO];
  assign w_off     = rd_data[OFFSET_HI:OFFSET_LO];
  assign ny_ext    = {1'b0, ny_q};
  assign y_lo      = {1'b0, w_y};
  assign y_hi      = y_lo + (COORD_W+1)'(SPRITE_LINE);
  assign qualify   = rd_vld_q && (w_status == STATUS_ACTIVE) && (ny_ext >= y_lo) && (ny_ext < y_hi);
  assign new_entry = '{index: rd_idx_q, x: w_x, row: 5'(ny_q - w_y), offset: w_off};

  // A word returning on the line_start edge belongs to the aborted scan and is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      ny_q      <= '0;
      back_cnt  <= '0;
      front_cnt <= '0;
      overflow  <= 1'b0;
      late      <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      late     <= line_start && (state != IDLE);
      rd_vld_q <= rd_en && !line_start;
      rd_idx_q <= rd_addr;
      if (line_start) begin
        front_q   <= back_q;
        front_cnt <= back_cnt;
        back_cnt  <= '0;
        overflow  <= 1'b0;
        ny_q      <= next_y;
        rd_addr   <= '0;
      end else begin
        if (rd_en) rd_addr <= (rd_addr == AW'(NUM_REGS - 1)) ? '0 : rd_addr + 1'b1;
        if (qualify) begin
          if (back_cnt < CW'(MAX_PER_LINE)) begin
            back_q[back_cnt[SW-1:0]] <= new_entry;
            back_cnt <= back_cnt + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  logic [MAX_PER_LINE-1:0] slot_match;
  logic [4:0]              slot_col [MAX_PER_LINE];

  for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_slot
    sprite_slot_match #(.LINE_LEN(SPRITE_LINE)) u_slot (
      .slot_x      (front_q[g].x),
      .en          (CW'(g) < front_cnt),
      .pixel_valid (pixel_valid),
      .pixel_x     (pixel_x),
      .match       (slot_match[g]),
      .col         (slot_col[g])
    );
  end

  logic          any_match;
  sprite_entry_t win;
  logic [4:0]    win_col;

  // Slots fill in bank order, so the lowest matching slot is also the lowest bank index
  always_comb begin
    any_match = 1'b0;
    win       = '0;
    win_col   = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (slot_match[i]) begin
        any_match = 1'b1;
        win       = front_q[i];
        win_col   = slot_col[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit        <= 1'b0;
      hit_index  <= '0;
      hit_col    <= '0;
      hit_row    <= '0;
      hit_offset <= '0;
    end else begin
      hit        <= any_match;
      hit_index  <= win.index;
      hit_col    <= win_col;
      hit_row    <= win.row;
      hit_offset <= win.offset;
    end
  end

endmodule
